// File: rtl/urx_frame_pkg.sv
// Shared definitions for the UART receive command-frame controller:
// state encoding, default header byte, gap-counter width and checksum helper.
package urx_frame_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DH    = 3'd2;
  localparam logic [2:0] ST_DL    = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_ISSUE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_DH    = ST_DH,
    S_DL    = ST_DL,
    S_CHK   = ST_CHK,
    S_ISSUE = ST_ISSUE
  } state_e;

  localparam logic [7:0] DEF_HEAD_BYTE = 8'hAA;
  localparam int         TMO_W         = 16;

  // 8-bit wrapping sum of the three payload bytes.
  function automatic logic [7:0] chk_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/urx_frame_ctrl_if.sv
// Configuration write port between the frame controller and the register bank.
interface urx_frame_ctrl_if;
  // Handshake: cfg_req rises with cfg_addr/cfg_wdata valid and holds them
  // stable until a cycle where cfg_ack=1 is sampled with cfg_req=1; that cycle
  // completes the write and cfg_req is low on the following cycle.
  logic        cfg_req;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ack;

  modport master (output cfg_req, output cfg_addr, output cfg_wdata, input cfg_ack);
  modport slave  (input cfg_req, input cfg_addr, input cfg_wdata, output cfg_ack);
endinterface

// File: rtl/urx_tmo_cnt.sv
// Inter-byte gap counter: counts pluse_us while enabled, expire is a combinational
// flag on the strobe that reaches LIMIT. clr has priority over counting.
module urx_tmo_cnt
  import urx_frame_pkg::*;
#(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic pluse_us,
  output logic expire
);

  localparam logic [TMO_W-1:0] LIMIT_M1 = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             step;

  assign step   = en & pluse_us & ~clr;
  assign expire = step & (cnt_q == LIMIT_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/urx_frame_ctrl.sv
// Assembles HEAD/ADDR/DH/DL[/CHK] frames from the UART byte stream and issues one
// config write per good frame. Define URX_CHKSUM_EN for the 5-byte checked format.
module urx_frame_ctrl
  import urx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  HEAD_BYTE  = DEF_HEAD_BYTE
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    pluse_us,
  input  logic [7:0]              rx_data,
  input  logic                    rx_vld,
  urx_frame_ctrl_if.master        cfg,
  output logic                    err_chk,
  output logic                    err_tmo,
  output logic                    err_ovr,
  output logic [7:0]              frm_cnt,
  output logic [2:0]              state_dbg
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dh_q, dh_d;
  logic [7:0] dl_q, dl_d;
  logic [7:0] frm_cnt_q, frm_cnt_d;
  logic       req_q, req_d;
  logic       err_tmo_q, err_tmo_d;
  logic       err_ovr_q, err_ovr_d;
  logic       tmo_clr, tmo_en, tmo_expire;

  // Any byte seen in a collecting state is accepted, so it always restarts the gap.
  assign tmo_en  = (state_q == S_ADDR) || (state_q == S_DH) ||
                   (state_q == S_DL)   || (state_q == S_CHK);
  assign tmo_clr = rx_vld || (state_q == S_IDLE) || (state_q == S_ISSUE);

  urx_tmo_cnt #(.LIMIT(TIMEOUT_US)) u_tmo_cnt (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .pluse_us (pluse_us),
    .expire   (tmo_expire)
  );

`ifdef URX_CHKSUM_EN
  logic err_chk_q, chk_bad;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    frm_cnt_d = frm_cnt_q;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
`ifdef URX_CHKSUM_EN
    chk_bad   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_vld && (rx_data == HEAD_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_vld) begin
          addr_d  = rx_data;
          state_d = S_DH;
        end
      end
      S_DH: begin
        if (rx_vld) begin
          dh_d    = rx_data;
          state_d = S_DL;
        end
      end
      S_DL: begin
        if (rx_vld) begin
          dl_d    = rx_data;
`ifdef URX_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef URX_CHKSUM_EN
      S_CHK: begin
        if (rx_vld) begin
          if (rx_data == chk_sum(addr_q, dh_q, dl_q)) begin
            state_d = S_ISSUE;
          end else begin
            chk_bad = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_ISSUE: begin
        // Bytes here are dropped; the pending write is never disturbed.
        if (rx_vld) err_ovr_d = 1'b1;
        if (req_q && cfg.cfg_ack) begin
          frm_cnt_d = frm_cnt_q + 8'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Expiry cannot coincide with an accepted byte: the byte clears the counter first.
    if (tmo_expire) begin
      err_tmo_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  assign req_d = (state_d == S_ISSUE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      frm_cnt_q <= '0;
      req_q     <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      frm_cnt_q <= frm_cnt_d;
      req_q     <= req_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

`ifdef URX_CHKSUM_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      err_chk_q <= 1'b0;
    end else begin
      err_chk_q <= chk_bad;
    end
  end
  assign err_chk = err_chk_q;
`else
  assign err_chk = 1'b0;
`endif

  assign cfg.cfg_req   = req_q;
  assign cfg.cfg_addr  = addr_q;
  assign cfg.cfg_wdata = {dh_q, dl_q};
  assign err_tmo       = err_tmo_q;
  assign err_ovr       = err_ovr_q;
  assign frm_cnt       = frm_cnt_q;
  assign state_dbg     = state_q;

endmodule
